mul_ctrl: RTL and testbench
===========================

Name: mul_ctrl

Overview:
Sequencing controller between the execute stage and the shared 34-cycle radix-2 Booth multiplier core. It accepts RV32M multiply ops (MUL, MULH, MULHSU, MULHU) over a valid/ready handshake and derives the operand-signedness controls. It holds `go` and the operands stable for the full run, selects the low or high result half, and returns a registered 32-bit result. A one-entry product cache returns the second op of a MULH*/MUL pair with the same operands in one cycle. Pipeline kills are absorbed without corrupting the core.

Parameters:
CACHE_EN, 1, 1 enables the one-entry product cache; 0 forces every op through the core.

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request this cycle
req_op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
req_a  in  32  rs1 operand
req_b  in  32  rs2 operand
kill  in  1  pipeline flush; discard in-flight/pending op
resp_valid  out  1  result available
resp_ready  in  1  consumer takes result
resp_data  out  32  selected result half
mul_go  out  1  core advance/enable
mul_sign0  out  1  core: r operand (rs2) signed
mul_sign1  out  1  core: m operand (rs1) signed
mul_m  out  32  core multiplicand (rs1)
mul_r  out  32  core multiplier (rs2)
mul_done  in  1  core: final cycle of run
mul_result  in  64  core product

Behaviour:
- Reset is `reset_n`, synchronous, active-low; clock is `clk`.
- Reset values:
  - state IDLE, cache invalid.
  - `req_ready` = 1, `resp_valid` = 0, `resp_data` = 0.
  - `mul_go` = 0, `mul_sign0`/`mul_sign1` = 0, `mul_m`/`mul_r` = 0.
- Reset also clears the core's sequencer, so reset mid-run is safe.
- Sign mapping (`sign1`/`sign0`):
  - MUL 0/0.
  - MULH 1/1.
  - MULHSU 1/0.
  - MULHU 0/0.
- States: IDLE, RUN, DRAIN, RESP.
- `req_ready` = 1 only in IDLE with `kill` low. Accept = `req_valid & req_ready`.
- IDLE, on accept:
  - Register op, a, b, and the sign pair into `mul_m`/`mul_r`/`mul_sign*`.
  - Cache hit → RESP. `resp_data` is the cached half; `resp_valid` is high the next cycle (1-cycle latency).
  - Miss → RUN.
- Cache hit rule (CACHE_EN=1, entry valid, a and b equal to the stored operands):
  - MUL hits regardless of sign pair.
  - MULH* hits only if the sign pair also matches the stored pair.
- RUN:
  - `mul_go` = 1 every cycle; `mul_m`, `mul_r`, and `mul_sign*` are held constant.
  - On `mul_done`:
    - Capture `mul_result` into the cache (operands, sign pair, valid = 1).
    - Load `resp_data` with [31:0] for MUL, else [63:32].
    - Go to RESP.
  - Miss latency: accept at cycle T, `mul_go` high T+1..T+34, `mul_done` at T+34, `resp_valid` at T+35.
- RESP:
  - `resp_valid` = 1; `resp_data` is stable until `resp_ready`.
  - On `resp_ready` → IDLE. A new request is accepted no earlier than the following cycle.
- Kill handling:
  - `kill` in RUN → DRAIN. The core cannot be aborted (it freezes if `go` drops), so `mul_go` stays high until `mul_done`.
  - On `mul_done` in DRAIN, update the cache (the product is valid), produce no response, and go to IDLE.
  - Further kills in DRAIN are ignored.
  - `kill` in RESP → IDLE; `resp_valid` drops next cycle, whether or not `resp_ready` was high that cycle.
  - `kill` with `req_valid` in IDLE → not accepted.
  - `kill` in the cycle `mul_done` arrives in RUN → DRAIN semantics: cache updated, no response.
- `mul_go` is 0 in IDLE and RESP. A core run is only ever started from the core's initial state.
- CACHE_EN=0: cache logic is absent; every op takes 35 cycles.
- Operands are captured at accept; later changes on `req_*` have no effect.

Test Plan:
- MUL a=7, b=6 → `resp_valid` at T+35, `resp_data`=0x0000002A; `mul_go` high exactly 34 cycles.
- MULH, MULHU, MULHSU with a=b=0xFFFFFFFF (cache disabled) → 0x00000000, 0xFFFFFFFE, 0xFFFFFFFF respectively.
- Cache pair: MULHU a=0x80000000, b=2 → 0x00000001 at T+35; then MUL same operands → 0x00000000 at T'+1 with `mul_go` never asserted.
- MULH after a MULHU with the same operands → miss (sign pair differs), full 35-cycle latency.
- `kill` at T+10 of a run → `mul_go` stays high to `mul_done`, no `resp_valid`, `req_ready` returns the cycle after `mul_done`; the next op's result is correct.
- Backpressure: `resp_ready` low for 5 cycles in RESP → `resp_valid`/`resp_data` stable and `req_ready` low; then `resp_ready`=1 → IDLE next cycle.

Source files
------------

// File: rtl/mul_ctrl.sv
// Sequencer between the execute stage and the shared 34-cycle Booth multiplier.
// It keeps the core operands and `go` stable for a whole run, and a one-entry product cache pairs MULH* and MUL ops.
module mul_ctrl #(
  parameter int CACHE_EN = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        kill,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        mul_go,
  output logic        mul_sign0,
  output logic        mul_sign1,
  output logic [31:0] mul_m,
  output logic [31:0] mul_r,
  input  logic        mul_done,
  input  logic [63:0] mul_result
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]  state_r;
  logic [1:0]  state_nxt_s;
  logic        op_mul_r;
  logic        accept_s;
  logic        sign1_s;
  logic        sign0_s;
  logic        hit_s;
  logic [31:0] hit_data_s;
  logic        core_busy_s;
  logic        cache_wr_s;

  assign req_ready   = (state_r == IDLE) && (kill == 1'b0);
  assign accept_s    = req_valid && req_ready;
  assign core_busy_s = (state_r == RUN) || (state_r == DRAIN);
  // The core freezes when go drops, so go must span the whole run even after a kill.
  assign mul_go      = core_busy_s;
  assign resp_valid  = (state_r == RESP);
  assign cache_wr_s  = core_busy_s && mul_done;

  assign sign1_s = (req_op == 2'b01) || (req_op == 2'b10);
  assign sign0_s = (req_op == 2'b01);

  generate
    if (CACHE_EN != 0) begin : g_cache
      logic        valid_r;
      logic [31:0] a_r;
      logic [31:0] b_r;
      logic        s1_r;
      logic        s0_r;
      logic [63:0] prod_r;

      // Product cache entry; any finished run (killed or not) refreshes it.
      always_ff @(posedge clk) begin
        if (reset_n == 1'b0) begin
          valid_r <= 1'b0;
          a_r     <= 32'd0;
          b_r     <= 32'd0;
          s1_r    <= 1'b0;
          s0_r    <= 1'b0;
          prod_r  <= 64'd0;
        end else if (cache_wr_s) begin
          valid_r <= 1'b1;
          a_r     <= mul_m;
          b_r     <= mul_r;
          s1_r    <= mul_sign1;
          s0_r    <= mul_sign0;
          prod_r  <= mul_result;
        end
      end

      // The low half is sign-independent, so MUL hits on operands alone.
      assign hit_s = valid_r && (req_a == a_r) && (req_b == b_r) &&
                     ((req_op == 2'b00) || ((sign1_s == s1_r) && (sign0_s == s0_r)));
      assign hit_data_s = (req_op == 2'b00) ? prod_r[31:0] : prod_r[63:32];
    end else begin : g_nocache
      assign hit_s      = 1'b0;
      assign hit_data_s = 32'd0;
    end
  endgenerate

  // Next-state selection.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = hit_s ? RESP : RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (mul_done) begin
          state_nxt_s = kill ? IDLE : RESP;
        end else if (kill) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DRAIN: begin
        if (mul_done) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      RESP: begin
        if (kill || resp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, operand capture and result register.
  always_ff @(posedge clk) begin
    if (reset_n == 1'b0) begin
      state_r   <= IDLE;
      op_mul_r  <= 1'b0;
      mul_m     <= 32'd0;
      mul_r     <= 32'd0;
      mul_sign1 <= 1'b0;
      mul_sign0 <= 1'b0;
      resp_data <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        op_mul_r  <= (req_op == 2'b00);
        mul_m     <= req_a;
        mul_r     <= req_b;
        mul_sign1 <= sign1_s;
        mul_sign0 <= sign0_s;
        if (hit_s) begin
          resp_data <= hit_data_s;
        end
      end
      if ((state_r == RUN) && mul_done && (kill == 1'b0)) begin
        resp_data <= op_mul_r ? mul_result[31:0] : mul_result[63:32];
      end
    end
  end

endmodule

// File: tb/tb_mul_ctrl.sv
// Directed bench for mul_ctrl with a behavioural 34-cycle core model.
// Expected results are queued at issue time and checked by an independent response monitor.
module tb_mul_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        kill;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        mul_go;
  logic        mul_sign0;
  logic        mul_sign1;
  logic [31:0] mul_m;
  logic [31:0] mul_r;
  logic        mul_done;
  logic [63:0] mul_result;

  int total = 0;
  int bad = 0;
  logic [31:0] sb[$];

  mul_ctrl #(.CACHE_EN(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .kill(kill),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .mul_go(mul_go), .mul_sign0(mul_sign0), .mul_sign1(mul_sign1),
    .mul_m(mul_m), .mul_r(mul_r), .mul_done(mul_done), .mul_result(mul_result)
  );

  always #5 clk = ~clk;

  // Core model: done on the 34th go cycle, product from sign-extended operands.
  int core_cnt;
  logic [65:0] ext_m, ext_r, prod;
  always @(posedge clk) begin
    if (!reset_n) core_cnt <= 0;
    else if (mul_go) core_cnt <= (core_cnt == 33) ? 0 : core_cnt + 1;
  end
  assign mul_done = mul_go && (core_cnt == 33);
  always_comb begin
    ext_m = {{34{mul_sign1 & mul_m[31]}}, mul_m};
    ext_r = {{34{mul_sign0 & mul_r[31]}}, mul_r};
    prod = ext_m * ext_r;
    mul_result = prod[63:0];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response monitor: pops the scoreboard on every completed handshake.
  always @(negedge clk) begin
    if (reset_n && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got %0h expected none", resp_data);
      end else begin
        chk("resp_data", {32'd0, resp_data}, {32'd0, sb.pop_front()});
      end
    end
  end

  // Issue one op, measure latency and go cycles, apply bp cycles of backpressure, then retire.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_lat, input int exp_go,
                       input logic es1, input logic es0, input int bp);
    int k;
    int go_cnt;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    sb.push_back(exp);
    @(negedge clk);
    chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_a = $urandom; req_b = $urandom; req_op = 2'b01;
    k = 1; go_cnt = 0;
    while (k <= 60) begin
      @(negedge clk);
      if (resp_valid) break;
      if (mul_go) go_cnt++;
      if (k == 1 && exp_go > 0) begin
        chk("mul_m", {32'd0, mul_m}, {32'd0, a});
        chk("mul_r", {32'd0, mul_r}, {32'd0, b});
        chk("signs", {62'd0, mul_sign1, mul_sign0}, {62'd0, es1, es0});
      end
      @(posedge clk); #1;
      k++;
    end
    chk("latency", k, exp_lat);
    chk("go_cycles", go_cnt, exp_go);
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_valid", {63'd0, resp_valid}, 64'd1);
      chk("bp_data", {32'd0, resp_data}, {32'd0, exp});
      chk("bp_ready_low", {63'd0, req_ready}, 64'd0);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    chk("back_idle", {62'd0, resp_valid, req_ready}, 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int k;
    int go_cnt;
    int ready_at;
    reset_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_a = 32'd0; req_b = 32'd0;
    kill = 1'b0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_resp_data", {32'd0, resp_data}, 64'd0);
    chk("rst_core", {mul_go, mul_sign1, mul_sign0, mul_m, mul_r}, 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    do_op(2'b00, 32'd7, 32'd6, 32'h0000002A, 35, 34, 1'b0, 1'b0, 0);
    do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 35, 34, 1'b1, 1'b1, 0);
    do_op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 35, 34, 1'b0, 1'b0, 0);
    do_op(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 35, 34, 1'b1, 1'b0, 0);
    do_op(2'b11, 32'h80000000, 32'd2, 32'h00000001, 35, 34, 1'b0, 1'b0, 0);
    do_op(2'b00, 32'h80000000, 32'd2, 32'h00000000, 1, 0, 1'b0, 1'b0, 0);
    do_op(2'b01, 32'h80000000, 32'd2, 32'hFFFFFFFF, 35, 34, 1'b1, 1'b1, 0);

    // Kill at T+10: no response, ready returns at T+35, cache still refreshed.
    req_valid = 1'b1; req_op = 2'b11; req_a = 32'h12345678; req_b = 32'h00000010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 1; go_cnt = 0; ready_at = 0;
    while (k <= 60 && ready_at == 0) begin
      kill = (k == 10);
      @(negedge clk);
      if (mul_go) go_cnt++;
      if (resp_valid) chk("kill_no_resp", {63'd0, resp_valid}, 64'd0);
      if (req_ready) ready_at = k;
      @(posedge clk); #1;
      k++;
    end
    kill = 1'b0;
    chk("kill_go_cycles", go_cnt, 34);
    chk("kill_ready_at", ready_at, 35);

    do_op(2'b00, 32'h12345678, 32'h00000010, 32'h23456780, 1, 0, 1'b0, 1'b0, 5);

    // Kill with a request in IDLE must not accept it.
    req_valid = 1'b1; kill = 1'b1; req_op = 2'b00; req_a = 32'd3; req_b = 32'd3;
    @(negedge clk);
    chk("kill_idle_ready", {63'd0, req_ready}, 64'd0);
    @(posedge clk); #1;
    req_valid = 1'b0; kill = 1'b0;
    @(negedge clk);
    chk("kill_idle_no_run", {62'd0, mul_go, resp_valid}, 64'd0);
    @(posedge clk); #1;

    do_op(2'b00, 32'd3, 32'd5, 32'h0000000F, 35, 34, 1'b0, 1'b0, 0);

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
